// File: rtl/pipeline_hazard_controller.sv
// RAW hazard / flush / freeze controller for a 5-stage pipeline, tracking EXE and MEM destinations.
// Define HAZARD_FORWARDING_EN to stall only on load-use (EXE slot); otherwise EXE and MEM are both checked.
module pipeline_hazard_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_rn,
    input  logic [3:0]  id_rdm,
    input  logic        id_use_rn,
    input  logic        id_two_src,
    input  logic [3:0]  id_dest,
    input  logic        id_wb_en,
    input  logic        id_mem_read,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        sram_ready,
    output logic        hazard,
    output logic        flush,
    output logic        freeze_all,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    localparam int unsigned REG_W = 4;
    localparam int unsigned CNT_W = 16;

`ifdef HAZARD_FORWARDING_EN
    localparam bit LOAD_USE_ONLY = 1'b1;
    localparam bit CHECK_MEM     = 1'b0;
`else
    localparam bit LOAD_USE_ONLY = 1'b0;
    localparam bit CHECK_MEM     = 1'b1;
`endif

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             wb_en;
        logic             mem_read;
    } slot_t;

    slot_t            exe_q, exe_d;
    slot_t            mem_q, mem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             raw_c;

    function automatic logic slot_match(input slot_t s, input logic [REG_W-1:0] r);
        return s.valid & s.wb_en & (s.dest == r);
    endfunction

    // A slot blocks ID if it writes a register ID reads; with forwarding only loads can block.
    function automatic logic slot_hit(input slot_t s, input logic [REG_W-1:0] rn,
                                      input logic [REG_W-1:0] rdm, input logic use_rn,
                                      input logic two_src);
        return (!LOAD_USE_ONLY || s.mem_read) &&
               ((use_rn && slot_match(s, rn)) || (two_src && slot_match(s, rdm)));
    endfunction

    always_comb begin
        raw_c = slot_hit(exe_q, id_rn, id_rdm, id_use_rn, id_two_src) ||
                (CHECK_MEM && slot_hit(mem_q, id_rn, id_rdm, id_use_rn, id_two_src));
    end

    // Control outputs: freeze dominates, flush beats hazard; reset masks hazard outright.
    always_comb begin
        freeze_all = mem_req & ~sram_ready;
        flush      = branch_taken & ~freeze_all;
        hazard     = raw_c & ~flush & ~freeze_all & ~rst;
    end

    always_comb begin
        exe_d       = exe_q;
        mem_d       = mem_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!freeze_all) begin
            mem_d = exe_q;
            if (flush || hazard) begin
                exe_d = '0;
            end else begin
                exe_d.valid    = 1'b1;
                exe_d.dest     = id_dest;
                exe_d.wb_en    = id_wb_en;
                exe_d.mem_read = id_mem_read;
            end
            if (hazard && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (flush && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_q       <= '0;
            mem_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            exe_q       <= exe_d;
            mem_q       <= mem_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule
